// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sync_fifo                                                       |
// | Brief    : Single-clock FIFO, first-word-fall-through read, occupancy out. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int c_AW  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [c_AW:0]    o_count
);

  localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Requests against a full/empty FIFO are dropped here, so the count can never over- or underflow.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == c_FULL);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/quick_spi_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : quick_spi_queue                                                 |
// | Brief    : Command/response queue that feeds quick_spi one transfer at a   |
// |            time and collects every returned word with credit checking.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module quick_spi_queue #(
  parameter  int MAX_DATA_LENGTH  = 16,
  parameter  int NUM_DEVICES      = 1,
  parameter  int CMD_DEPTH        = 4,
  parameter  int RSP_DEPTH        = 4,
  parameter  int STARTUP_CYCLES   = 4,
  localparam int c_NUM_DATA_WIDTH = $clog2(MAX_DATA_LENGTH),
  localparam int c_W              = MAX_DATA_LENGTH * NUM_DEVICES
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  logic [c_NUM_DATA_WIDTH-1:0] cmd_num_data_i,
  input  logic [c_W-1:0]              cmd_data_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [c_W-1:0]              rsp_data_o,
  output logic                        spi_request_o,
  output logic [c_NUM_DATA_WIDTH-1:0] spi_num_data_o,
  output logic [c_W-1:0]              spi_data_o,
  input  logic [c_W-1:0]              spi_data_i,
  input  logic                        spi_data_valid_i,
  output logic                        busy_o
);

  localparam int c_CMD_W  = c_NUM_DATA_WIDTH + c_W;
  localparam int c_CMD_CW = $clog2(CMD_DEPTH) + 1;
  localparam int c_RSP_CW = $clog2(RSP_DEPTH) + 1;
  localparam int c_SU_W   = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;

  localparam logic [1:0] c_STARTUP = 2'd0;
  localparam logic [1:0] c_IDLE    = 2'd1;
  localparam logic [1:0] c_BUSY    = 2'd2;

  logic [1:0]                  r_state;
  logic [1:0]                  w_state_next;
  logic [c_SU_W-1:0]           r_startup_cnt;
  logic                        w_startup_done;
  logic                        w_outstanding;
  logic                        w_complete;
  logic                        w_credit_ok;
  logic                        w_issue;
  logic                        r_spi_request;
  logic [c_NUM_DATA_WIDTH-1:0] r_spi_num_data;
  logic [c_W-1:0]              r_spi_data;
  logic                        w_cmd_full;
  logic                        w_cmd_empty;
  logic [c_CMD_W-1:0]          w_cmd_head;
  logic [c_CMD_CW-1:0]         w_cmd_count;
  logic                        w_rsp_full;
  logic                        w_rsp_empty;
  logic [c_RSP_CW-1:0]         w_rsp_count;

  sync_fifo #(.WIDTH(c_CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .i_push  (cmd_valid_i && cmd_ready_o),
    .i_pop   (w_issue),
    .i_data  ({cmd_num_data_i, cmd_data_i}),
    .o_data  (w_cmd_head),
    .o_full  (w_cmd_full),
    .o_empty (w_cmd_empty),
    .o_count (w_cmd_count)
  );

  sync_fifo #(.WIDTH(c_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .i_push  (w_complete && !w_rsp_full),
    .i_pop   (rsp_ready_i),
    .i_data  (spi_data_i),
    .o_data  (rsp_data_o),
    .o_full  (w_rsp_full),
    .o_empty (w_rsp_empty),
    .o_count (w_rsp_count)
  );

  assign w_startup_done = (r_startup_cnt == c_SU_W'(STARTUP_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_startup_cnt <= '0;
    else if (r_state == c_STARTUP && !w_startup_done) r_startup_cnt <= r_startup_cnt + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= c_STARTUP;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_STARTUP: if (w_startup_done) w_state_next = c_IDLE;
      c_IDLE:    if (w_issue) w_state_next = c_BUSY;
      c_BUSY:    if (spi_data_valid_i && !w_issue) w_state_next = c_IDLE;
      default:   w_state_next = c_STARTUP;
    endcase
  end

  // The word of the transfer in flight (or completing now) already owns a response slot,
  // so a new issue needs one more free slot on top of it; a same-cycle pop is not credited.
  always_comb begin
    w_outstanding = (r_state == c_BUSY);
    w_complete    = spi_data_valid_i && w_outstanding;
    w_credit_ok   = (int'(w_rsp_count) + int'(w_outstanding) + 1) <= RSP_DEPTH;
    w_issue       = !w_cmd_empty && (r_state != c_STARTUP) &&
                    ((r_state == c_IDLE) || spi_data_valid_i) && w_credit_ok;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_spi_request  <= 1'b0;
      r_spi_num_data <= '0;
      r_spi_data     <= '0;
    end else begin
      r_spi_request <= w_issue;
      if (w_issue) {r_spi_num_data, r_spi_data} <= w_cmd_head;
    end
  end

  assign spi_request_o  = r_spi_request;
  assign spi_num_data_o = r_spi_num_data;
  assign spi_data_o     = r_spi_data;
  assign cmd_ready_o    = !w_cmd_full;
  assign rsp_valid_o    = !w_rsp_empty;
  assign busy_o         = w_outstanding || (w_cmd_count != '0) || (w_rsp_count != '0);

endmodule
`default_nettype wire
